// File: rtl/oup_pkg.sv
// Shared constants for the ULPI register engine: opcodes, FSM states and
// TX CMD encoding helpers.
package oup_pkg;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_REG_WRITE = 8'h01;
    localparam logic [7:0] OP_REG_READ  = 8'h02;

    localparam logic [1:0] TXCMD_PFX_WRITE = 2'b10;
    localparam logic [1:0] TXCMD_PFX_READ  = 2'b11;

    localparam logic [5:0] PHYREG_ADDR_MAX = 6'h2E;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BUS = 3'd1,
        ST_TXCMD    = 3'd2,
        ST_WDATA    = 3'd3,
        ST_WSTP     = 3'd4,
        ST_RTURN    = 3'd5,
        ST_RDATA    = 3'd6,
        ST_RTURN2   = 3'd7
    } oup_ulpi_state_t;

    // Upper address bits must be clear and the low six bits within the map.
    function automatic logic phyreg_addr_ok(input logic [7:0] addr);
        return (addr[7:6] == 2'b00) && (addr[5:0] <= PHYREG_ADDR_MAX);
    endfunction

    function automatic logic [7:0] txcmd_byte(input logic is_read, input logic [5:0] addr);
        return {(is_read ? TXCMD_PFX_READ : TXCMD_PFX_WRITE), addr};
    endfunction

endpackage

// File: rtl/oup_ulpi_rxcmd.sv
// Tracks the previous-cycle dir level and captures RX CMD bytes sent by the
// PHY outside turnaround and outside the register-read data cycle.
module oup_ulpi_rxcmd (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_dir,
    input  logic       i_nxt,
    input  logic [7:0] i_data,
    input  logic       i_in_rdata,
    output logic       o_dir_prev,
    output logic [7:0] o_rx_cmd_byte,
    output logic       o_rx_cmd_valid
);

    logic       r_dir_prev;
    logic [7:0] r_rx_cmd_byte;
    logic       r_rx_cmd_valid;
    logic       w_capture;

    assign w_capture = i_dir && r_dir_prev && !i_nxt && !i_in_rdata;

    // dir history and RX CMD capture register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dir_prev     <= 1'b0;
            r_rx_cmd_byte  <= 8'h00;
            r_rx_cmd_valid <= 1'b0;
        end else begin
            r_dir_prev     <= i_dir;
            r_rx_cmd_valid <= w_capture;
            if (w_capture) begin
                r_rx_cmd_byte <= i_data;
            end
        end
    end

    assign o_dir_prev     = r_dir_prev;
    assign o_rx_cmd_byte  = r_rx_cmd_byte;
    assign o_rx_cmd_valid = r_rx_cmd_valid;

endmodule

// File: rtl/oup_ulpi_reg_engine.sv
// ULPI link-side engine: runs one PHY register write or read per instruction
// and reports done/aborted; RX CMD capture is delegated to oup_ulpi_rxcmd.
import oup_pkg::*;

module oup_ulpi_reg_engine #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       ulpi_clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] ins_instruction_i,
    input  logic       ins_exec_i,
    output logic       ins_exec_done_o,
    output logic       ins_exec_aborted_o,
    input  logic [7:0] phyreg_addr_i,
    input  logic [7:0] phyreg_data_i,
    output logic [7:0] phyreg_data_o,
    output logic       phyreg_data_load_o,
    output logic [7:0] rx_cmd_byte_o,
    output logic       rx_cmd_valid_o,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_data_oe_o,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic       ulpi_stp_o
);

    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    oup_ulpi_state_t r_state;
    oup_ulpi_state_t w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic          r_is_read;
    logic [5:0]    r_addr;
    logic [7:0]    r_wdata;

    logic          r_done;
    logic          r_abort;
    logic [7:0]    r_rdata;
    logic          r_load;
    logic [7:0]    r_udata;
    logic          r_oe;
    logic          r_stp;

    logic          w_done_nxt;
    logic          w_abort_nxt;
    logic [7:0]    w_rdata_nxt;
    logic          w_load_nxt;
    logic [7:0]    w_udata_nxt;
    logic          w_oe_nxt;
    logic          w_stp_nxt;
    logic          w_latch;
    logic          w_go_abort;

    logic          w_dir_prev;
    logic          w_bus_free;
    logic          w_timeout;

    oup_ulpi_rxcmd u_rxcmd (
        .i_clk          (ulpi_clk_i),
        .i_rst_n        (rst_n_i),
        .i_dir          (ulpi_dir_i),
        .i_nxt          (ulpi_nxt_i),
        .i_data         (ulpi_data_i),
        .i_in_rdata     (r_state == ST_RDATA),
        .o_dir_prev     (w_dir_prev),
        .o_rx_cmd_byte  (rx_cmd_byte_o),
        .o_rx_cmd_valid (rx_cmd_valid_o)
    );

    assign w_bus_free = !ulpi_dir_i && !w_dir_prev;
    assign w_timeout  = (r_cnt >= TO_LIMIT);

    // next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
        w_load_nxt  = 1'b0;
        w_rdata_nxt = r_rdata;
        w_udata_nxt = r_udata;
        w_oe_nxt    = r_oe;
        w_stp_nxt   = 1'b0;
        w_latch     = 1'b0;
        w_go_abort  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ins_exec_i) begin
                    w_latch = 1'b1;
                    case (ins_instruction_i)
                        OP_NOP: w_done_nxt = 1'b1;
                        OP_REG_WRITE, OP_REG_READ: begin
                            if (!phyreg_addr_ok(phyreg_addr_i)) begin
                                w_go_abort = 1'b1;
                            end else if (w_bus_free) begin
                                w_state_nxt = ST_TXCMD;
                                w_oe_nxt    = 1'b1;
                                w_udata_nxt = txcmd_byte(ins_instruction_i == OP_REG_READ,
                                                         phyreg_addr_i[5:0]);
                            end else begin
                                w_state_nxt = ST_WAIT_BUS;
                            end
                        end
                        default: w_go_abort = 1'b1;
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_BUS: begin
                if (w_bus_free) begin
                    w_state_nxt = ST_TXCMD;
                    w_oe_nxt    = 1'b1;
                    w_udata_nxt = txcmd_byte(r_is_read, r_addr);
                end else if (w_timeout) begin
                    w_go_abort = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT_BUS;
                end
            end
            ST_TXCMD: begin
                if (ulpi_dir_i) begin
                    w_go_abort = 1'b1;
                end else if (ulpi_nxt_i) begin
                    if (r_is_read) begin
                        w_state_nxt = ST_RTURN;
                        w_oe_nxt    = 1'b0;
                        w_udata_nxt = 8'h00;
                    end else begin
                        w_state_nxt = ST_WDATA;
                        w_udata_nxt = r_wdata;
                    end
                end else if (w_timeout) begin
                    w_go_abort = 1'b1;
                end else begin
                    w_state_nxt = ST_TXCMD;
                end
            end
            ST_WDATA: begin
                if (ulpi_dir_i) begin
                    w_go_abort = 1'b1;
                end else if (ulpi_nxt_i) begin
                    w_state_nxt = ST_WSTP;
                    w_udata_nxt = 8'h00;
                    w_stp_nxt   = 1'b1;
                end else if (w_timeout) begin
                    w_go_abort = 1'b1;
                end else begin
                    w_state_nxt = ST_WDATA;
                end
            end
            ST_WSTP: begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
                w_oe_nxt    = 1'b0;
                w_udata_nxt = 8'h00;
            end
            ST_RTURN: begin
                if (ulpi_dir_i) begin
                    w_state_nxt = ST_RDATA;
                end else if (w_timeout) begin
                    w_go_abort = 1'b1;
                end else begin
                    w_state_nxt = ST_RTURN;
                end
            end
            ST_RDATA: begin
                if (ulpi_dir_i) begin
                    w_state_nxt = ST_RTURN2;
                    w_rdata_nxt = ulpi_data_i;
                    w_load_nxt  = 1'b1;
                end else begin
                    w_go_abort = 1'b1;
                end
            end
            ST_RTURN2: begin
                if (!ulpi_dir_i) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_timeout) begin
                    w_go_abort = 1'b1;
                end else begin
                    w_state_nxt = ST_RTURN2;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_oe_nxt    = 1'b0;
                w_udata_nxt = 8'h00;
            end
        endcase
        // Every abort path releases the bus and returns to IDLE.
        if (w_go_abort) begin
            w_state_nxt = ST_IDLE;
            w_abort_nxt = 1'b1;
            w_oe_nxt    = 1'b0;
            w_udata_nxt = 8'h00;
            w_stp_nxt   = 1'b0;
        end else begin
            w_abort_nxt = 1'b0;
        end
    end

    // state, timeout counter, command latch and registered outputs
    always_ff @(posedge ulpi_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_is_read <= 1'b0;
            r_addr    <= 6'h00;
            r_wdata   <= 8'h00;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
            r_rdata   <= 8'h00;
            r_load    <= 1'b0;
            r_udata   <= 8'h00;
            r_oe      <= 1'b0;
            r_stp     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= {CW{1'b0}};
            end else if (r_cnt != {CW{1'b1}}) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_latch) begin
                r_is_read <= (ins_instruction_i == OP_REG_READ);
                r_addr    <= phyreg_addr_i[5:0];
                r_wdata   <= phyreg_data_i;
            end
            r_done  <= w_done_nxt;
            r_abort <= w_abort_nxt;
            r_rdata <= w_rdata_nxt;
            r_load  <= w_load_nxt;
            r_udata <= w_udata_nxt;
            r_oe    <= w_oe_nxt;
            r_stp   <= w_stp_nxt;
        end
    end

    assign ins_exec_done_o    = r_done;
    assign ins_exec_aborted_o = r_abort;
    assign phyreg_data_o      = r_rdata;
    assign phyreg_data_load_o = r_load;
    assign ulpi_data_o        = r_udata;
    assign ulpi_data_oe_o     = r_oe;
    assign ulpi_stp_o         = r_stp;

endmodule

// File: tb/tb_oup_ulpi_reg_engine.sv
// Directed bench: each scenario builds its PHY stimulus and the expected
// output timeline from transaction rules, then checks every cycle.
module tb_oup_ulpi_reg_engine;

    localparam int LEN = 24;

    logic       ulpi_clk = 1'b0;
    logic       rst_n;
    logic [7:0] ins_instruction;
    logic       ins_exec;
    logic [7:0] phyreg_addr;
    logic [7:0] phyreg_data_in;
    logic [7:0] ulpi_data_in;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic       ins_exec_done;
    logic       ins_exec_aborted;
    logic [7:0] phyreg_data_out;
    logic       phyreg_data_load;
    logic [7:0] rx_cmd_byte;
    logic       rx_cmd_valid;
    logic [7:0] ulpi_data_out;
    logic       ulpi_data_oe;
    logic       ulpi_stp;

    always #5 ulpi_clk = ~ulpi_clk;

    oup_ulpi_reg_engine #(.TIMEOUT_CYCLES(16)) dut (
        .ulpi_clk_i         (ulpi_clk),
        .rst_n_i            (rst_n),
        .ins_instruction_i  (ins_instruction),
        .ins_exec_i         (ins_exec),
        .ins_exec_done_o    (ins_exec_done),
        .ins_exec_aborted_o (ins_exec_aborted),
        .phyreg_addr_i      (phyreg_addr),
        .phyreg_data_i      (phyreg_data_in),
        .phyreg_data_o      (phyreg_data_out),
        .phyreg_data_load_o (phyreg_data_load),
        .rx_cmd_byte_o      (rx_cmd_byte),
        .rx_cmd_valid_o     (rx_cmd_valid),
        .ulpi_data_i        (ulpi_data_in),
        .ulpi_data_o        (ulpi_data_out),
        .ulpi_data_oe_o     (ulpi_data_oe),
        .ulpi_dir_i         (ulpi_dir),
        .ulpi_nxt_i         (ulpi_nxt),
        .ulpi_stp_o         (ulpi_stp)
    );

    logic [29:0] outs;
    assign outs = {ulpi_data_oe, ulpi_stp, ins_exec_done, ins_exec_aborted, phyreg_data_load,
                   rx_cmd_valid, ulpi_data_out, phyreg_data_out, rx_cmd_byte};

    int n_tests = 0;
    int n_fail  = 0;
    int done_at, abort_at, load_cnt, rxv_cnt, stp_cnt, oe_cnt;

    logic       s_exec [LEN];
    logic       s_dir  [LEN];
    logic       s_nxt  [LEN];
    logic       rd_cyc [LEN];
    logic [7:0] s_din  [LEN];
    logic [7:0] s_op, s_addr, s_wd;

    logic       e_oe [LEN], e_stp [LEN], e_done [LEN], e_abort [LEN], e_load [LEN], e_rxv [LEN];
    logic [7:0] e_data [LEN], e_rdata [LEN], e_rxb [LEN];
    logic [7:0] e_rdval;
    logic [7:0] m_rdata = 8'h00;
    logic [7:0] m_rxb   = 8'h00;

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
        end
    endtask

    task automatic scn_clear();
        for (int t = 0; t < LEN; t++) begin
            s_exec[t] = 1'b0; s_dir[t] = 1'b0; s_nxt[t] = 1'b0; rd_cyc[t] = 1'b0;
            s_din[t]  = 8'h00;
            e_oe[t] = 1'b0; e_stp[t] = 1'b0; e_done[t] = 1'b0; e_abort[t] = 1'b0;
            e_load[t] = 1'b0; e_rxv[t] = 1'b0;
            e_data[t] = 8'h00; e_rdata[t] = 8'h00; e_rxb[t] = 8'h00;
        end
        s_op = 8'h00; s_addr = 8'h00; s_wd = 8'h00; e_rdval = 8'h00;
    endtask

    task automatic scn_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] wd);
        s_exec[0] = 1'b1; s_op = op; s_addr = addr; s_wd = wd;
    endtask

    // Write: TX CMD from cycle s held l1 extra cycles, data held l2 extra, then stp, then done.
    task automatic exp_write(input int s, input int l1, input int l2,
                             input logic [7:0] addr, input logic [7:0] wd);
        int w;
        for (int c = s; c <= s + l1; c++) begin e_oe[c] = 1'b1; e_data[c] = 8'h80 | addr; end
        s_nxt[s + l1] = 1'b1;
        for (int c = s + l1 + 1; c <= s + l1 + 1 + l2; c++) begin e_oe[c] = 1'b1; e_data[c] = wd; end
        s_nxt[s + l1 + 1 + l2] = 1'b1;
        w = s + l1 + l2 + 2;
        e_oe[w] = 1'b1; e_stp[w] = 1'b1; e_data[w] = 8'h00;
        e_done[w + 1] = 1'b1;
    endtask

    // Read: PHY raises dir d cycles late, returns val, then holds dir h cycles sending hold.
    task automatic exp_read(input int s, input int l1, input int d, input int h,
                            input logic [7:0] addr, input logic [7:0] val, input logic [7:0] hold);
        int r;
        for (int c = s; c <= s + l1; c++) begin e_oe[c] = 1'b1; e_data[c] = 8'hC0 | addr; end
        s_nxt[s + l1] = 1'b1;
        r = s + l1 + 2 + d;
        s_dir[r - 1] = 1'b1; s_dir[r] = 1'b1; s_din[r] = val; rd_cyc[r] = 1'b1;
        for (int c = 1; c <= h; c++) begin s_dir[r + c] = 1'b1; s_din[r + c] = hold; end
        e_load[r + 1] = 1'b1; e_rdval = val;
        e_done[r + h + 2] = 1'b1;
    endtask

    // Fill the persistent read-data and RX CMD timelines from the stimulus.
    task automatic finalize();
        logic [7:0] rd;
        logic [7:0] rx;
        logic       prev;
        rd = m_rdata; rx = m_rxb;
        for (int t = 0; t < LEN; t++) begin
            if (e_load[t]) rd = e_rdval;
            e_rdata[t] = rd;
            if (t > 0) begin
                if (t >= 2) prev = s_dir[t - 2];
                else        prev = 1'b0;
                if (s_dir[t - 1] && prev && !s_nxt[t - 1] && !rd_cyc[t - 1]) begin
                    e_rxv[t] = 1'b1;
                    rx = s_din[t - 1];
                end
            end
            e_rxb[t] = rx;
        end
    endtask

    task automatic drive(input int t);
        ins_exec        = s_exec[t];
        ins_instruction = s_op;
        phyreg_addr     = s_addr;
        phyreg_data_in  = s_wd;
        ulpi_dir        = s_dir[t];
        ulpi_nxt        = s_nxt[t];
        ulpi_data_in    = s_din[t];
    endtask

    task automatic cmp_cycle(input string nm, input int t);
        logic [29:0] exp;
        exp = {e_oe[t], e_stp[t], e_done[t], e_abort[t], e_load[t], e_rxv[t],
               e_data[t], e_rdata[t], e_rxb[t]};
        n_tests++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: outputs 0x%08h required 0x%08h", nm, t, outs, exp);
        end
        if (ins_exec_done && done_at < 0)     done_at = t;
        if (ins_exec_aborted && abort_at < 0) abort_at = t;
        if (phyreg_data_load) load_cnt++;
        if (rx_cmd_valid)     rxv_cnt++;
        if (ulpi_stp)         stp_cnt++;
        if (ulpi_data_oe)     oe_cnt++;
    endtask

    task automatic run_scn(input string nm);
        done_at = -1; abort_at = -1; load_cnt = 0; rxv_cnt = 0; stp_cnt = 0; oe_cnt = 0;
        finalize();
        for (int t = 0; t < LEN; t++) begin
            @(posedge ulpi_clk); #1;
            drive(t);
            @(negedge ulpi_clk);
            cmp_cycle(nm, t);
        end
        m_rdata = e_rdata[LEN - 1];
        m_rxb   = e_rxb[LEN - 1];
    endtask

    initial begin
        rst_n = 1'b0;
        scn_clear();
        drive(0);
        #12;
        chk("reset_state", int'(outs), 0);
        @(negedge ulpi_clk);
        rst_n = 1'b1;

        scn_clear(); scn_cmd(8'h01, 8'h0A, 8'h55); exp_write(1, 2, 0, 8'h0A, 8'h55);
        run_scn("write_0a");
        chk("write_0a_done_cycle", done_at, 6);
        chk("write_0a_stp_cycles", stp_cnt, 1);

        scn_clear(); scn_cmd(8'h02, 8'h00, 8'h00); exp_read(1, 0, 0, 0, 8'h00, 8'h24, 8'h00);
        run_scn("read_00");
        chk("read_00_done_cycle", done_at, 5);
        chk("read_00_loads", load_cnt, 1);
        chk("read_00_data", int'(phyreg_data_out), 8'h24);

        scn_clear();
        for (int t = 2; t <= 5; t++) begin s_dir[t] = 1'b1; s_din[t] = 8'h4E; end
        run_scn("rxcmd_idle");
        chk("rxcmd_idle_pulses", rxv_cnt, 3);
        chk("rxcmd_idle_byte", int'(rx_cmd_byte), 8'h4E);

        scn_clear(); scn_cmd(8'h01, 8'h04, 8'h77);
        e_oe[1] = 1'b1; e_oe[2] = 1'b1; e_data[1] = 8'h84; e_data[2] = 8'h84;
        s_dir[2] = 1'b1; s_dir[3] = 1'b1; s_din[2] = 8'h2A; s_din[3] = 8'h2A;
        e_abort[3] = 1'b1;
        run_scn("abort_txcmd");
        chk("abort_txcmd_cycle", abort_at, 3);
        chk("abort_txcmd_stp", stp_cnt, 0);

        scn_clear(); scn_cmd(8'h02, 8'h15, 8'h00);
        for (int c = 1; c <= 16; c++) begin e_oe[c] = 1'b1; e_data[c] = 8'hD5; end
        e_abort[17] = 1'b1;
        run_scn("timeout_txcmd");
        chk("timeout_txcmd_cycle", abort_at, 17);

        scn_clear(); scn_cmd(8'h07, 8'h01, 8'h00); e_abort[1] = 1'b1;
        run_scn("bad_opcode");
        chk("bad_opcode_cycle", abort_at, 1);
        chk("bad_opcode_oe", oe_cnt, 0);

        scn_clear(); scn_cmd(8'h02, 8'h2F, 8'h00); e_abort[1] = 1'b1;
        run_scn("bad_addr_2f");
        chk("bad_addr_2f_cycle", abort_at, 1);
        chk("bad_addr_2f_oe", oe_cnt, 0);

        scn_clear(); scn_cmd(8'h01, 8'h40, 8'h12); e_abort[1] = 1'b1;
        run_scn("bad_addr_40");

        scn_clear(); scn_cmd(8'h00, 8'h00, 8'h00); e_done[1] = 1'b1;
        run_scn("nop");

        scn_clear(); scn_cmd(8'h01, 8'h2E, 8'hA5); s_exec[2] = 1'b1;
        exp_write(1, 0, 3, 8'h2E, 8'hA5);
        run_scn("write_2e_exec_ignored");

        scn_clear(); scn_cmd(8'h02, 8'h2E, 8'h00); exp_read(1, 1, 1, 1, 8'h2E, 8'h81, 8'h1B);
        run_scn("read_2e_slow");

        scn_clear(); scn_cmd(8'h02, 8'h03, 8'h00);
        e_oe[1] = 1'b1; e_data[1] = 8'hC3; s_nxt[1] = 1'b1; s_dir[2] = 1'b1; rd_cyc[3] = 1'b1;
        e_abort[4] = 1'b1;
        run_scn("abort_rdata");

        scn_clear(); scn_cmd(8'h01, 8'h07, 8'h66);
        e_oe[1] = 1'b1; e_data[1] = 8'h87; s_nxt[1] = 1'b1;
        e_oe[2] = 1'b1; e_data[2] = 8'h66; e_oe[3] = 1'b1; e_data[3] = 8'h66;
        s_dir[3] = 1'b1; e_abort[4] = 1'b1;
        run_scn("abort_wdata");

        scn_clear(); scn_cmd(8'h01, 8'h12, 8'h3C);
        s_dir[0] = 1'b1; s_dir[1] = 1'b1; s_din[0] = 8'h11; s_din[1] = 8'h11;
        exp_write(4, 0, 1, 8'h12, 8'h3C);
        run_scn("write_wait_bus");

        scn_clear(); scn_cmd(8'h01, 8'h0A, 8'h99); s_nxt[1] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(posedge ulpi_clk); #1;
            drive(t);
            @(negedge ulpi_clk);
        end
        chk("rst_pre_oe", int'(ulpi_data_oe), 1);
        chk("rst_pre_data", int'(ulpi_data_out), 8'h99);
        @(posedge ulpi_clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", int'(outs), 0);
        scn_clear(); drive(0);
        for (int t = 0; t < 2; t++) begin
            @(negedge ulpi_clk);
            chk("rst_held_outputs", int'(outs), 0);
        end
        rst_n = 1'b1;
        m_rdata = 8'h00; m_rxb = 8'h00;

        scn_clear(); scn_cmd(8'h00, 8'h00, 8'h00); e_done[1] = 1'b1;
        run_scn("nop_after_reset");
        chk("nop_after_reset_cycle", done_at, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
